// File: rtl/decoder_pipe.sv
// Pipelined instruction decoder. It keeps a busy scoreboard per register with a RAW interlock,
// drives a registered decoded word, and counts hazard-stall cycles with a saturating counter.
module decoder_pipe #(
   parameter int INST_W     = 16,
   parameter int OP_W       = 4,
   parameter int RA_W       = 3,
   parameter int IMM_W      = 8,
   parameter int DATA_W     = 16,
   parameter bit IMM_SIGNED = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              res,
   input  logic [INST_W-1:0] inst,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic              dec_ready,
   output logic              dec_valid,
   output logic [OP_W-1:0]   op,
   output logic [RA_W-1:0]   lsel,
   output logic [RA_W-1:0]   rsel,
   output logic [RA_W-1:0]   osel,
   output logic              lout,
   output logic              rout,
   output logic              oin,
   output logic [DATA_W-1:0] imm,
   output logic              imm_en,
   output logic              illegal,
   input  logic              wb_valid,
   input  logic [RA_W-1:0]   wb_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              dbg_state
);

   localparam int NREG = 2**RA_W;
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_LOADI = OP_W'(6);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   state_t state, state_nxt;

   logic [OP_W-1:0]   f_op;
   logic [RA_W-1:0]   f_rd, f_rs, f_rt;
   logic [IMM_W-1:0]  f_imm;
   logic              d_alu, d_ldi, d_ill;
   logic [DATA_W-1:0] d_ext;
   logic [NREG-1:0]   busy, busy_eff, busy_nxt, wb_mask, set_mask;
   logic              hazard, out_free, accept, stall_cond, cnt_inc;

   assign f_op  = inst[INST_W-1 -: OP_W];
   assign f_rd  = inst[INST_W-OP_W-1 -: RA_W];
   assign f_rs  = inst[INST_W-OP_W-RA_W-1 -: RA_W];
   assign f_rt  = inst[INST_W-OP_W-2*RA_W-1 -: RA_W];
   assign f_imm = inst[IMM_W-1:0];

   always_comb begin
      d_alu = (f_op >= OP_ADD) && (f_op <= OP_XOR);
      d_ldi = (f_op == OP_LOADI);
      d_ill = (f_op > OP_LOADI);
      if (IMM_SIGNED)
         d_ext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
      else
         d_ext = {{(DATA_W-IMM_W){1'b0}}, f_imm};
   end

   // Handshake: a word moves when valid & ready in the same cycle. inst_ready never looks at
   // inst_valid. A same-cycle write-back clears its busy bit before the hazard check, and a set
   // from the accept wins over a clear of the same register.
   always_comb begin
      wb_mask    = wb_valid ? (NREG'(1) << wb_sel) : '0;
      busy_eff   = busy & ~wb_mask;
      hazard     = d_alu & (busy_eff[f_rs] | busy_eff[f_rt]);
      out_free   = ~dec_valid | dec_ready;
      inst_ready = out_free & ~hazard;
      accept     = inst_valid & inst_ready;
      set_mask   = (accept & (d_alu | d_ldi)) ? (NREG'(1) << f_rd) : '0;
      busy_nxt   = busy_eff | set_mask;
      stall_cond = inst_valid & hazard & out_free;
   end

   always_comb begin
      state_nxt = RUN;
      cnt_inc   = 1'b0;
      if (stall_cond) begin
         state_nxt = STALL;
         cnt_inc   = 1'b1;
      end
   end

   assign dbg_state = (state == STALL);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= RUN;
         busy      <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         if (cnt_inc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // When nothing new is accepted, the decoded fields hold their values and only dec_valid drops.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         dec_valid <= 1'b0;
         op        <= '0;
         lsel      <= '0;
         rsel      <= '0;
         osel      <= '0;
         lout      <= 1'b0;
         rout      <= 1'b0;
         oin       <= 1'b0;
         imm       <= '0;
         imm_en    <= 1'b0;
         illegal   <= 1'b0;
      end else if (accept) begin
         dec_valid <= 1'b1;
         op        <= f_op;
         lsel      <= f_rs;
         rsel      <= f_rt;
         osel      <= f_rd;
         lout      <= d_alu;
         rout      <= d_alu;
         oin       <= d_alu | d_ldi;
         imm       <= d_ldi ? d_ext : '0;
         imm_en    <= d_ldi;
         illegal   <= d_ill;
      end else if (dec_ready) begin
         dec_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe. DUT a uses zero-extension and a 16-bit counter. DUT b uses
// sign-extension and a 2-bit counter. Both DUTs share the same stimulus.
module tb_decoder_pipe;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   logic [15:0] inst;
   logic        inst_valid, dec_ready, wb_valid;
   logic [2:0]  wb_sel;

   logic        ir_a, dv_a, lo_a, ro_a, oi_a, ie_a, il_a, st_a;
   logic [3:0]  op_a;
   logic [2:0]  ls_a, rs_a, os_a;
   logic [15:0] imm_a, cnt_a;
   logic        ir_b, dv_b, lo_b, ro_b, oi_b, ie_b, il_b, st_b;
   logic [3:0]  op_b;
   logic [2:0]  ls_b, rs_b, os_b;
   logic [15:0] imm_b;
   logic [1:0]  cnt_b;

   decoder_pipe #(.IMM_SIGNED(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .res(res), .inst(inst), .inst_valid(inst_valid), .inst_ready(ir_a),
      .dec_ready(dec_ready), .dec_valid(dv_a), .op(op_a), .lsel(ls_a), .rsel(rs_a), .osel(os_a),
      .lout(lo_a), .rout(ro_a), .oin(oi_a), .imm(imm_a), .imm_en(ie_a), .illegal(il_a),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .stall_cnt(cnt_a), .dbg_state(st_a));

   decoder_pipe #(.IMM_SIGNED(1'b1), .CNT_W(2)) dut_b (
      .clk(clk), .res(res), .inst(inst), .inst_valid(inst_valid), .inst_ready(ir_b),
      .dec_ready(dec_ready), .dec_valid(dv_b), .op(op_b), .lsel(ls_b), .rsel(rs_b), .osel(os_b),
      .lout(lo_b), .rout(ro_b), .oin(oi_b), .imm(imm_b), .imm_en(ie_b), .illegal(il_b),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .stall_cnt(cnt_b), .dbg_state(st_b));

   logic [35:0] obs_a, obs_b;
   assign obs_a = {st_a, dv_a, op_a, ls_a, rs_a, os_a, lo_a, ro_a, oi_a, imm_a, ie_a, il_a};
   assign obs_b = {st_b, dv_b, op_b, ls_b, rs_b, os_b, lo_b, ro_b, oi_b, imm_b, ie_b, il_b};

   // Reference model. A word is {op, lsel, rsel, osel, lout, rout, oin, imm, imm_en, illegal}.
   bit          m_busy[8];
   logic [33:0] exp_q[$];
   logic [33:0] m_word_a, m_word_b;
   bit          m_st;
   int          m_cnt;
   logic [35:0] exp_a, exp_b;
   logic [15:0] exp_ca;
   logic [1:0]  exp_cb;
   logic [1:0]  obs_rdy, exp_rdy;

   int n_vec = 0;
   int n_bad = 0;

   task automatic model_clear();
      for (int r = 0; r < 8; r++) m_busy[r] = 1'b0;
      exp_q.delete();
      m_word_a = '0;
      m_word_b = '0;
      m_st     = 1'b0;
      m_cnt    = 0;
      exp_a    = '0;
      exp_b    = '0;
      exp_ca   = '0;
      exp_cb   = '0;
   endtask

   task automatic apply_reset();
      res = 1'b0;
      model_clear();
      @(posedge clk);
      #1 res = 1'b1;
   endtask

   // Advances one clock. It samples inst_ready mid-cycle and the registered outputs #1 after the edge.
   task automatic cycle();
      int opv, rd, rs, rt, iv;
      bit alu, ws, haz, free, rdy, acc, stl;
      bit beff[8];
      logic [33:0] wa, wbv;
      @(negedge clk);
      opv = int'(inst) / 4096;
      rd  = (int'(inst) / 512) % 8;
      rs  = (int'(inst) / 64) % 8;
      rt  = (int'(inst) / 8) % 8;
      iv  = int'(inst) % 256;
      for (int r = 0; r < 8; r++) beff[r] = m_busy[r] && !(wb_valid && (int'(wb_sel) == r));
      alu  = (opv >= 1) && (opv <= 5);
      ws   = (opv == 6);
      haz  = alu && (beff[rs] || beff[rt]);
      free = (exp_q.size() == 0) || dec_ready;
      rdy  = free && !haz;
      acc  = inst_valid && rdy;
      stl  = inst_valid && haz && free;
      exp_rdy = {rdy, rdy};
      obs_rdy = {ir_a, ir_b};
      wa  = {4'(opv), 3'(rs), 3'(rt), 3'(rd), alu, alu, (alu || ws),
             (ws ? 16'(iv) : 16'd0), ws, (opv > 6)};
      wbv = {4'(opv), 3'(rs), 3'(rt), 3'(rd), alu, alu, (alu || ws),
             (ws ? ((iv >= 128) ? 16'(iv + 65280) : 16'(iv)) : 16'd0), ws, (opv > 6)};
      @(posedge clk);
      if (res) begin
         for (int r = 0; r < 8; r++) m_busy[r] = beff[r];
         if (acc && (alu || ws)) m_busy[rd] = 1'b1;
         if (exp_q.size() != 0 && dec_ready) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(wa);
            m_word_a = wa;
            m_word_b = wbv;
         end
         m_st = stl;
         if (stl) m_cnt++;
      end
      exp_a  = {m_st, (exp_q.size() != 0), m_word_a};
      exp_b  = {m_st, (exp_q.size() != 0), m_word_b};
      exp_ca = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      exp_cb = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
      #1;
   endtask

   task automatic set_in(input logic [15:0] i, input logic v, input logic dr,
                         input logic wv, input logic [2:0] ws);
      inst = i; inst_valid = v; dec_ready = dr; wb_valid = wv; wb_sel = ws;
   endtask

   task automatic test_reset();
      set_in(16'h1000, 1'b1, 1'b1, 1'b0, 3'd0);
      res = 1'b1;
      #1 res = 1'b0;
      model_clear();
      #1;
      n_vec++;
      if ({obs_a, obs_b, cnt_a, cnt_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got a=%h b=%h cnt=%h/%h, want all 0", obs_a, obs_b, cnt_a, cnt_b);
      end
      n_vec++;
      if ({ir_a, ir_b} !== 2'b11) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 11", {ir_a, ir_b});
      end
      @(posedge clk);
      #1 res = 1'b1;
      cycle();
      n_vec++;
      if (obs_a !== exp_a || dv_a !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_first_accept: got %h want %h", obs_a, exp_a);
      end
   endtask

   task automatic test_alu_decode();
      apply_reset();
      set_in(16'h1650, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if ({dv_a, op_a, ls_a, rs_a, os_a, lo_a, ro_a, oi_a, ie_a, il_a, imm_a} !==
          {1'b1, 4'd1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0}) begin
         n_bad++;
         $display("FAIL alu_fields: got %h want op1 l1 r2 o3 en111", obs_a);
      end
      n_vec++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
         n_bad++;
         $display("FAIL alu_model: got %h/%h want %h/%h", obs_a, obs_b, exp_a, exp_b);
      end
      set_in(16'h18C0, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if (obs_rdy !== 2'b00 || obs_rdy !== exp_rdy) begin
         n_bad++;
         $display("FAIL alu_busy_rd: ready got %b want 00", obs_rdy);
      end
   endtask

   task automatic test_loadi();
      apply_reset();
      set_in(16'h6A80, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if ({imm_a, imm_b, os_a, ie_a, ie_b, lo_a, ro_a, oi_a} !==
          {16'h0080, 16'hFF80, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL loadi_ext: got imm %h/%h osel %0d want 0080/FF80 osel 5", imm_a, imm_b, os_a);
      end
      set_in(16'h6C11, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
         n_bad++;
         $display("FAIL loadi_pos: got %h/%h want %h/%h", obs_a, obs_b, exp_a, exp_b);
      end
   endtask

   task automatic test_raw_stall();
      apply_reset();
      set_in(16'h6401, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      set_in(16'h1688, 1'b1, 1'b1, 1'b0, 3'd0);
      for (int c = 0; c < 4; c++) begin
         cycle();
         n_vec++;
         if (obs_rdy !== 2'b00 || cnt_a !== 16'(c + 1) || cnt_a !== exp_ca || cnt_b !== exp_cb) begin
            n_bad++;
            $display("FAIL raw_stall c%0d: ready %b cnt %0d/%0d want 00 %0d/%0d",
                     c, obs_rdy, cnt_a, cnt_b, c + 1, exp_cb);
         end
      end
      set_in(16'h1688, 1'b1, 1'b1, 1'b1, 3'd2);
      cycle();
      n_vec++;
      if (obs_rdy !== 2'b11 || op_a !== 4'd1 || os_a !== 3'd3 || cnt_a !== 16'd4 || obs_a !== exp_a) begin
         n_bad++;
         $display("FAIL raw_release: ready %b op %0d cnt %0d got %h want %h",
                  obs_rdy, op_a, cnt_a, obs_a, exp_a);
      end
   endtask

   task automatic test_backpressure();
      logic [35:0] snap;
      apply_reset();
      set_in(16'h1650, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      snap = obs_a;
      set_in(16'h6C11, 1'b1, 1'b0, 1'b0, 3'd0);
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_vec++;
         if (obs_a !== snap || obs_rdy !== 2'b00 || cnt_a !== 16'd0 || obs_a !== exp_a) begin
            n_bad++;
            $display("FAIL backpressure c%0d: got %h ready %b cnt %0d want %h 00 0",
                     c, obs_a, obs_rdy, cnt_a, snap);
         end
      end
      dec_ready = 1'b1;
      cycle();
      n_vec++;
      if (obs_rdy !== 2'b11 || op_a !== 4'd6 || dv_a !== 1'b1 || obs_b !== exp_b) begin
         n_bad++;
         $display("FAIL backpressure_release: ready %b got %h want %h", obs_rdy, obs_b, exp_b);
      end
   endtask

   task automatic test_illegal_sat();
      apply_reset();
      set_in(16'hF000, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if ({il_a, lo_a, ro_a, oi_a, ie_a, imm_a, dv_a} !== {1'b1, 4'b0, 16'h0, 1'b1}) begin
         n_bad++;
         $display("FAIL illegal_decode: got %h want illegal only", obs_a);
      end
      set_in(16'h1200, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      n_vec++;
      if (obs_rdy !== 2'b11) begin
         n_bad++;
         $display("FAIL illegal_no_busy: ready got %b want 11", obs_rdy);
      end
      set_in(16'h6401, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      set_in(16'h1688, 1'b1, 1'b1, 1'b0, 3'd0);
      repeat (6) cycle();
      n_vec++;
      if (cnt_b !== 2'd3 || cnt_a !== 16'd6) begin
         n_bad++;
         $display("FAIL stall_saturate: cnt %0d/%0d want 6/3", cnt_a, cnt_b);
      end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      set_in(16'h6401, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      set_in(16'h1688, 1'b1, 1'b1, 1'b0, 3'd0);
      repeat (2) cycle();
      res = 1'b0;
      model_clear();
      #1;
      n_vec++;
      if ({obs_a, obs_b, cnt_a, cnt_b} !== '0 || {ir_a, ir_b} !== 2'b11) begin
         n_bad++;
         $display("FAIL midstall_reset: got %h cnt %0d ready %b want 0 0 11", obs_a, cnt_a, {ir_a, ir_b});
      end
      #1 res = 1'b1;
      cycle();
      n_vec++;
      if (op_a !== 4'd1 || dv_a !== 1'b1 || obs_a !== exp_a || cnt_a !== 16'd0) begin
         n_bad++;
         $display("FAIL midstall_reaccept: got %h cnt %0d want %h 0", obs_a, cnt_a, exp_a);
      end
   endtask

   task automatic test_random();
      logic [3:0] rop;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
         set_in({rop, 12'($urandom)}, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
         cycle();
         n_vec++;
         if (obs_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL random_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy);
         end
         n_vec++;
         if (obs_a !== exp_a || obs_b !== exp_b || cnt_a !== exp_ca || cnt_b !== exp_cb) begin
            n_bad++;
            $display("FAIL random_out c%0d: got %h/%h cnt %0d/%0d want %h/%h cnt %0d/%0d",
                     c, obs_a, obs_b, cnt_a, cnt_b, exp_a, exp_b, exp_ca, exp_cb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_decode();
      test_loadi();
      test_raw_stall();
      test_backpressure();
      test_illegal_sat();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
